// File: rtl/calc_kbd_pkg.sv
// Shared types and constants for the calculator keypad scanner.
// Key codes follow a 7-8-9-/ top-row layout with code = row*4 + col.
package calc_kbd_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    typedef enum logic [1:0] {
        StScan,
        StPressDb,
        StHeld,
        StRelDb
    } kbd_state_e;

    localparam logic [3:0] KEY_7   = 4'd0;
    localparam logic [3:0] KEY_8   = 4'd1;
    localparam logic [3:0] KEY_9   = 4'd2;
    localparam logic [3:0] KEY_DIV = 4'd3;
    localparam logic [3:0] KEY_4   = 4'd4;
    localparam logic [3:0] KEY_5   = 4'd5;
    localparam logic [3:0] KEY_6   = 4'd6;
    localparam logic [3:0] KEY_MUL = 4'd7;
    localparam logic [3:0] KEY_1   = 4'd8;
    localparam logic [3:0] KEY_2   = 4'd9;
    localparam logic [3:0] KEY_3   = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_CLR = 4'd12;
    localparam logic [3:0] KEY_0   = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_ADD = 4'd15;

    // Index of the lowest-numbered active-low row; row 0 wins ties.
    function automatic logic [1:0] first_low_row(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines.
// Flops reset to 1 so the rows read as idle out of reset.
module row_sync
    import calc_kbd_pkg::*;
#(
    parameter int unsigned Width = NUM_ROWS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce and a one-cycle key strobe.
// Define KEYPAD_REPEAT_EN to enable auto-repeat strobes while a key is held.
module keypad_scanner
    import calc_kbd_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 50000,
    parameter int unsigned REPEAT_CNT   = 25000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int unsigned DwellW = $clog2(SCAN_DIV + 1);
    localparam int unsigned DbW    = $clog2(DEBOUNCE_CNT + 1);

    logic [NUM_ROWS-1:0] row_s;

    kbd_state_e  state_q, state_d;
    logic [1:0]  col_q, col_d;
    logic [1:0]  row_q, row_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [DbW-1:0]    db_q, db_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        held_q, held_d;
    logic        row_hit;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RptW = $clog2(DEBOUNCE_CNT + REPEAT_CNT + 1);
    logic [RptW-1:0] rpt_q, rpt_d, rpt_lim;
    logic            rpt_first_q, rpt_first_d;
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CNT;
`endif

    row_sync #(
        .Width(NUM_ROWS)
    ) u_row_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (row_n),
        .q_o  (row_s)
    );

    // The latched row is held low by the frozen column.
    assign row_hit = ~row_s[row_q];

`ifdef KEYPAD_REPEAT_EN
    // First repeat waits out the press debounce as well as one repeat period.
    assign rpt_lim = rpt_first_q ? RptW'(DEBOUNCE_CNT + REPEAT_CNT - 1) : RptW'(REPEAT_CNT - 1);
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        db_d    = db_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
`endif
        unique case (state_q)
            StScan: begin
                if (dwell_q == DwellW'(SCAN_DIV - 1)) begin
                    dwell_d = '0;
                    if (row_s == 4'hF) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_d   = first_low_row(row_s);
                        db_d    = '0;
                        state_d = StPressDb;
                    end
                end else begin
                    dwell_d = dwell_q + DwellW'(1);
                end
            end
            StPressDb: begin
                if (!row_hit) begin
                    state_d = StScan;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                end else if (db_q == DbW'(DEBOUNCE_CNT)) begin
                    state_d = StHeld;
                    code_d  = {row_q, col_q};
                    valid_d = 1'b1;
                    held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                    rpt_d       = '0;
                    rpt_first_d = 1'b1;
`endif
                end else begin
                    db_d = db_q + DbW'(1);
                end
            end
            StHeld: begin
                if (!row_hit) begin
                    state_d = StRelDb;
                    db_d    = '0;
`ifdef KEYPAD_REPEAT_EN
                    rpt_d   = '0;
                end else if (rpt_q == rpt_lim) begin
                    valid_d     = 1'b1;
                    rpt_d       = '0;
                    rpt_first_d = 1'b0;
                end else begin
                    rpt_d = rpt_q + RptW'(1);
`endif
                end
            end
            StRelDb: begin
                if (row_hit) begin
                    state_d = StHeld;
                end else if (db_q == DbW'(DEBOUNCE_CNT)) begin
                    state_d = StScan;
                    held_d  = 1'b0;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                end else begin
                    db_d = db_q + DbW'(1);
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StScan;
            col_q   <= '0;
            row_q   <= '0;
            dwell_q <= '0;
            db_q    <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            db_q    <= db_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign col_n     = ~(4'b0001 << col_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives the rows and a
// scoreboard of expected strobes (code and cycle) is checked on key_valid.
module tb_keypad_scanner;

    localparam int unsigned ScanDiv  = 4;
    localparam int unsigned Db       = 8;
    localparam int unsigned Rpt      = 20;
    // Press seen at dwell 0 of its column: rest of dwell, then Db+1 in PRESS_DB.
    localparam int unsigned PressLat = ScanDiv + Db + 1;
    // Release: 2 sync cycles, 1 HELD cycle, then Db+1 cycles in REL_DB.
    localparam int unsigned RelLat   = 2 + 1 + Db + 1;

    typedef struct packed {
        logic [3:0] code;
        int         at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];

    keypad_scanner #(
        .SCAN_DIV    (ScanDiv),
        .DEBOUNCE_CNT(Db),
        .REPEAT_CNT  (Rpt)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A closed switch pulls its row low only while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] colv(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic key(input int r, input int c, input logic on);
        pressed[r*4+c] = on;
    endtask

    // Wait until column c has just become active (its first dwell cycle).
    task automatic wait_col(input int c);
        int n;
        n = 0;
        while (col_n === colv(c) && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (col_n !== colv(c) && n < 128) begin
            @(negedge clk);
            n++;
        end
        if (col_n !== colv(c)) chk("wait_col", col_n, colv(c));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (key_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", key_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("strobe_code", key_code, e.code);
                chk("strobe_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_col", col_n, 4'b1110);
        chk("rst_code", key_code, 4'd0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        rst_n = 1'b1;

        // Idle scan: each column for ScanDiv cycles, no strobes.
        for (int k = 0; k < 64; k++) begin
            chk("idle_col", col_n, colv((k / ScanDiv) % 4));
            @(negedge clk);
        end

        // Clean press of row 2 / column 1, then release.
        wait_col(1);
        key(2, 1, 1'b1);
        sb.push_back('{code: 4'd9, at: cyc + PressLat});
        repeat (PressLat - 1) @(negedge clk);
        chk("press_held_early", key_held, 1'b0);
        @(negedge clk);
        chk("press_held", key_held, 1'b1);
        chk("press_code", key_code, 4'd9);
        repeat (10) @(negedge clk);
        key(2, 1, 1'b0);
        repeat (RelLat - 1) @(negedge clk);
        chk("rel_held_early", key_held, 1'b1);
        @(negedge clk);
        chk("rel_held", key_held, 1'b0);
        chk("rel_next_col", col_n, colv(2));
        chk("rel_code_kept", key_code, 4'd9);

        // Press bounce: 3 low cycles in PRESS_DB then high.
        wait_col(3);
        key(0, 3, 1'b1);
        repeat (5) @(negedge clk);
        key(0, 3, 1'b0);
        repeat (2) @(negedge clk);
        chk("bounce_col_frozen", col_n, colv(3));
        @(negedge clk);
        chk("bounce_col_next", col_n, colv(0));
        repeat (20) @(negedge clk);
        chk("bounce_held", key_held, 1'b0);

        // Release bounce: row returns low in REL_DB cycle 5.
        wait_col(0);
        key(3, 0, 1'b1);
        sb.push_back('{code: 4'd12, at: cyc + PressLat});
        repeat (PressLat) @(negedge clk);
        chk("rb_held", key_held, 1'b1);
        key(3, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 6) key(3, 0, 1'b1);
            chk("rb_held_stays", key_held, 1'b1);
            @(negedge clk);
        end
        key(3, 0, 1'b0);
        repeat (RelLat - 1) @(negedge clk);
        chk("rb_final_early", key_held, 1'b1);
        @(negedge clk);
        chk("rb_final", key_held, 1'b0);
        chk("rb_next_col", col_n, colv(1));

        // Two keys in one column, then a third key while held.
        wait_col(1);
        key(1, 1, 1'b1);
        key(3, 1, 1'b1);
        sb.push_back('{code: 4'd5, at: cyc + PressLat});
        repeat (PressLat + 3) @(negedge clk);
        key(0, 1, 1'b1);
        repeat (20) @(negedge clk);
        chk("multi_code", key_code, 4'd5);
        chk("multi_held", key_held, 1'b1);
        pressed = '0;
        repeat (RelLat) @(negedge clk);
        chk("multi_released", key_held, 1'b0);

        // Reset in the middle of PRESS_DB.
        wait_col(2);
        key(1, 2, 1'b1);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_col", col_n, 4'b1110);
        chk("midrst_code", key_code, 4'd0);
        chk("midrst_valid", key_valid, 1'b0);
        chk("midrst_held", key_held, 1'b0);
        pressed = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("postrst_col", col_n, colv((k / ScanDiv) % 4));
            @(negedge clk);
        end

        // Long hold: single strobe, or repeats at HELD+28 and HELD+48.
        wait_col(1);
        key(0, 1, 1'b1);
        sb.push_back('{code: 4'd1, at: cyc + PressLat});
`ifdef KEYPAD_REPEAT_EN
        sb.push_back('{code: 4'd1, at: cyc + PressLat + Db + Rpt});
        sb.push_back('{code: 4'd1, at: cyc + PressLat + Db + 2 * Rpt});
`endif
        repeat (PressLat + 58) @(negedge clk);
        chk("hold_held", key_held, 1'b1);
        key(0, 1, 1'b0);
        repeat (RelLat) @(negedge clk);
        chk("hold_released", key_held, 1'b0);

        repeat (30) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
